// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle datapath (master) and its controller (slave).
interface multicycle_controller_if;
    logic [31:0] inst;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, MemWrite, RegWrite;
    logic        AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0]  ALUControl;
    logic        carry_in;
    logic [1:0]  shft_ctrl;
    logic [4:0]  shamt_ctrl;
    logic [1:0]  mux_mine;
    logic        bx_mux;
    logic [3:0]  state;

    modport master (
        output inst, ALUFlags,
        input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
        input  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, carry_in,
        input  shft_ctrl, shamt_ctrl, mux_mine, bx_mux, state
    );

    modport slave (
        input  inst, ALUFlags,
        output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
        output ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, carry_in,
        output shft_ctrl, shamt_ctrl, mux_mine, bx_mux, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller: FSM plus NZCV flags register, combinational control decode.
// Define CTRL_BRANCH_LINK_EN to enable BL (link write to R14) and BX (register branch).
module multicycle_controller (
    input  logic                    clock,
    input  logic                    rst,
    multicycle_controller_if.slave  bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t      r_state;
    logic [3:0]  r_flags;
    logic        w_n, w_z, w_c, w_v;
    logic        w_cond_ok;
    logic        w_is_bx, w_is_bl;
    logic [3:0]  w_op;
    logic        w_unused;

    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign w_op     = bus.inst[24:21];
    assign w_unused = ^{bus.inst[19:12], bus.inst[4:0]};

`ifdef CTRL_BRANCH_LINK_EN
    assign w_is_bx = (bus.inst[27:4] == 24'h12FFF1);
    assign w_is_bl = bus.inst[24] & ~w_is_bx;
`else
    assign w_is_bx = 1'b0;
    assign w_is_bl = 1'b0;
`endif

    always_comb begin
        w_cond_ok = 1'b0;
        case (bus.inst[31:28])
            4'b0000: w_cond_ok = w_z;
            4'b0001: w_cond_ok = ~w_z;
            4'b0010: w_cond_ok = w_c;
            4'b0011: w_cond_ok = ~w_c;
            4'b0100: w_cond_ok = w_n;
            4'b0101: w_cond_ok = ~w_n;
            4'b0110: w_cond_ok = w_v;
            4'b0111: w_cond_ok = ~w_v;
            4'b1000: w_cond_ok = w_c & ~w_z;
            4'b1001: w_cond_ok = ~w_c | w_z;
            4'b1010: w_cond_ok = (w_n == w_v);
            4'b1011: w_cond_ok = (w_n != w_v);
            4'b1100: w_cond_ok = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ok = w_z | (w_n != w_v);
            4'b1110: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_flags <= 4'b0000;
        end else begin
            if ((r_state == S_EXECR || r_state == S_EXECI) && bus.inst[20])
                r_flags <= bus.ALUFlags;
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_cond_ok)
                        r_state <= S_FETCH;
                    else if (w_is_bx)
                        r_state <= S_BRANCH;
                    else begin
                        case (bus.inst[27:26])
                            2'b00:   r_state <= bus.inst[25] ? S_EXECI : S_EXECR;
                            2'b01:   r_state <= S_MEMADR;
                            2'b10:   r_state <= S_BRANCH;
                            default: r_state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: r_state <= bus.inst[20] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXECR,
                S_EXECI:  r_state <= S_ALUWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ImmSrc     = 2'b00;
        bus.RegSrc     = 2'b00;
        bus.ALUControl = 4'b0000;
        bus.carry_in   = 1'b0;
        bus.shft_ctrl  = 2'b00;
        bus.shamt_ctrl = 5'd0;
        bus.mux_mine   = 2'b00;
        bus.bx_mux     = 1'b0;
        bus.state      = r_state;
        case (r_state)
            S_FETCH: begin
                bus.IRWrite    = 1'b1;
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = 4'b0100;
                bus.ResultSrc  = 2'b10;
                bus.PCWrite    = 1'b1;
            end
            // Second PC+4 so ALUOut holds PC+8 for R15 reads
            S_DECODE: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = 4'b0100;
            end
            S_EXECR, S_EXECI: begin
                bus.ALUControl = w_op;
                bus.carry_in   = (w_op == 4'b0101 || w_op == 4'b0110) & w_c;
                if (r_state == S_EXECR) begin
                    bus.shft_ctrl  = bus.inst[6:5];
                    bus.shamt_ctrl = bus.inst[11:7];
                end else begin
                    bus.ALUSrcB = 2'b01;
                end
            end
            S_ALUWB: bus.RegWrite = (w_op[3:2] != 2'b10);
            S_MEMADR: begin
                bus.ALUSrcB    = 2'b01;
                bus.ImmSrc     = 2'b01;
                bus.ALUControl = bus.inst[23] ? 4'b0100 : 4'b0010;
            end
            S_MEMRD: bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWR: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                bus.RegSrc   = 2'b10;
            end
            S_BRANCH: begin
                bus.PCWrite   = 1'b1;
                bus.ResultSrc = 2'b10;
                if (w_is_bx) begin
                    bus.bx_mux     = 1'b1;
                    bus.ALUControl = 4'b1101;
                end else begin
                    bus.RegSrc     = 2'b01;
                    bus.ALUSrcB    = 2'b01;
                    bus.ImmSrc     = 2'b10;
                    bus.ALUControl = 4'b0100;
                    if (w_is_bl) begin
                        bus.mux_mine = 2'b11;
                        bus.RegWrite = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule
